// File: rtl/axis_width_conv_flush.sv
// Stream width converter: packs N-bit words MSB-first into LCM-bit blocks kept in a
// ring of NBUF buffers, drains each block as LCM/M words of M bits, with tlast flush.
module axis_width_conv_flush #(
  parameter int N = 8,
  parameter int M = 5,
  parameter int LCM = 40,
  parameter int NBUF = 2,
  parameter logic [N-1:0] PAD_WORD = {N{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       s_axis_tnext,
  input  logic [N-1:0]               s_axis_tdata,
  input  logic                       s_axis_tfirst,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tvalid,
  input  logic                       m_axis_tnext,
  output logic [M-1:0]               m_axis_tdata,
  output logic                       m_axis_tfirst,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  output logic [$clog2(NBUF+1)-1:0]  occupancy,
  output logic [15:0]                pad_count
);
  localparam int K  = LCM / N;
  localparam int J  = LCM / M;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam int JW = (J > 1) ? $clog2(J) : 1;
  localparam int PW = (NBUF > 1) ? $clog2(NBUF) : 1;
  localparam int OW = $clog2(NBUF + 1);

  if (LCM % N != 0) begin : gen_chk_n
    $error("axis_width_conv_flush: LCM must be a multiple of N");
  end
  if (LCM % M != 0) begin : gen_chk_m
    $error("axis_width_conv_flush: LCM must be a multiple of M");
  end
  if (NBUF < 1) begin : gen_chk_nbuf
    $error("axis_width_conv_flush: NBUF must be at least 1");
  end

  typedef enum logic {FILL, PAD} fillState_e;

  fillState_e      state_q, state_d;
  logic [N-1:0]    bufMem_q [NBUF][K];
  logic [NBUF-1:0] firstMem_q, lastMem_q;
  logic [IW-1:0]   idx_q, idx_d;
  logic [JW-1:0]   j_q;
  logic [PW-1:0]   wPtr_q, rPtr_q;
  logic [OW-1:0]   occ_q;
  logic [15:0]     padCnt_q;
  logic            padLast_q, padLast_d;

  logic            canFill, idxLast, jLast, offered, takeWord;
  logic            wrEn, latchFirst, commit, commitLast, padInc, pop;
  logic [N-1:0]    wrData;
  logic [LCM-1:0]  headBlk;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(NBUF - 1)) ? '0 : p + 1'b1;
  endfunction

  // A new block may only start while a free buffer exists; the one being filled stays reserved.
  assign canFill  = occ_q < OW'(NBUF);
  assign idxLast  = idx_q == IW'(K - 1);
  assign jLast    = j_q == JW'(J - 1);
  assign offered  = rst && s_axis_tvalid && canFill;
  assign takeWord = offered && (idx_q == '0 || !s_axis_tfirst);
  assign pop      = m_axis_tvalid && m_axis_tnext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FILL;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (offered && !takeWord)                           state_d = PAD;
        else if (takeWord && !idxLast && s_axis_tlast)      state_d = PAD;
      end
      PAD:     if (idxLast) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // A tfirst word arriving mid-block is left unconsumed; the block is padded out first.
  always_comb begin
    s_axis_tnext = 1'b0;
    wrEn         = 1'b0;
    wrData       = s_axis_tdata;
    latchFirst   = 1'b0;
    commit       = 1'b0;
    commitLast   = padLast_q;
    padInc       = 1'b0;
    idx_d        = idx_q;
    padLast_d    = padLast_q;
    case (state_q)
      FILL: begin
        if (takeWord) begin
          s_axis_tnext = 1'b1;
          wrEn         = 1'b1;
          latchFirst   = idx_q == '0;
          if (idxLast) begin
            commit     = 1'b1;
            commitLast = s_axis_tlast;
            idx_d      = '0;
          end else begin
            idx_d     = idx_q + 1'b1;
            padLast_d = s_axis_tlast;
          end
        end else if (offered) begin
          padLast_d = 1'b0;
        end
      end
      PAD: begin
        wrEn   = 1'b1;
        wrData = PAD_WORD;
        padInc = 1'b1;
        if (idxLast) begin
          commit = 1'b1;
          idx_d  = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q      <= '0;
      j_q        <= '0;
      wPtr_q     <= '0;
      rPtr_q     <= '0;
      occ_q      <= '0;
      padCnt_q   <= '0;
      padLast_q  <= 1'b0;
      firstMem_q <= '0;
      lastMem_q  <= '0;
    end else begin
      idx_q     <= idx_d;
      padLast_q <= padLast_d;
      if (padInc && padCnt_q != 16'hFFFF) padCnt_q <= padCnt_q + 16'd1;
      if (latchFirst) firstMem_q[wPtr_q] <= s_axis_tfirst;
      if (commit) begin
        lastMem_q[wPtr_q] <= commitLast;
        wPtr_q            <= nextPtr(wPtr_q);
      end
      if (pop) begin
        if (jLast) begin
          j_q    <= '0;
          rPtr_q <= nextPtr(rPtr_q);
        end else begin
          j_q <= j_q + 1'b1;
        end
      end
      if (commit && !(pop && jLast))      occ_q <= occ_q + 1'b1;
      else if (!commit && pop && jLast)   occ_q <= occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) bufMem_q[wPtr_q][idx_q] <= wrData;
  end

  assign m_axis_tvalid = occ_q != '0;

  always_comb begin
    headBlk = '0;
    for (int i = 0; i < K; i++) headBlk[LCM-1-i*N -: N] = bufMem_q[rPtr_q][i];
    m_axis_tdata = '0;
    for (int w = 0; w < J; w++) begin
      if (m_axis_tvalid && j_q == JW'(w)) m_axis_tdata = headBlk[LCM-1-w*M -: M];
    end
  end

  assign m_axis_tfirst = m_axis_tvalid && firstMem_q[rPtr_q] && (j_q == '0);
  assign m_axis_tlast  = m_axis_tvalid && lastMem_q[rPtr_q] && jLast;
  assign occupancy     = occ_q;
  assign pad_count     = padCnt_q;

endmodule

// File: tb/tb_axis_width_conv_flush.sv
// Bench for axis_width_conv_flush: a block-level reference model pushes expected output
// words when input words are offered/consumed; DUT pops are compared in order.
module tb_axis_width_conv_flush;
  localparam int N = 8;
  localparam int M = 5;
  localparam int LCM = 40;
  localparam int NBUF = 2;
  localparam int K = LCM / N;
  localparam int J = LCM / M;
  localparam logic [N-1:0] PAD = 8'h00;

  typedef struct packed {logic [N-1:0] data; logic first; logic last;} inWord_t;
  typedef struct packed {logic [M-1:0] data; logic first; logic last;} outWord_t;
  typedef enum int {SINK_POP, SINK_HOLD, SINK_RANDOM} sinkMode_e;

  logic clk = 1'b0;
  logic rst;
  logic s_axis_tnext, s_axis_tfirst, s_axis_tlast, s_axis_tvalid;
  logic [N-1:0] s_axis_tdata;
  logic m_axis_tnext, m_axis_tfirst, m_axis_tlast, m_axis_tvalid;
  logic [M-1:0] m_axis_tdata;
  logic [$clog2(NBUF+1)-1:0] occupancy;
  logic [15:0] pad_count;

  inWord_t   stimQ[$];
  outWord_t  expQ[$];
  sinkMode_e sinkMode = SINK_POP;
  int checkCount = 0;
  int passCount = 0;
  int acceptedCount = 0;
  int mIdx = 0;
  int mPad = 0;
  logic [LCM-1:0] mBlock = '0;
  logic mFirst = 1'b0;
  bit progress;

  always #5 clk = ~clk;

  axis_width_conv_flush #(.N(N), .M(M), .LCM(LCM), .NBUF(NBUF), .PAD_WORD(PAD)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tnext(s_axis_tnext), .s_axis_tdata(s_axis_tdata), .s_axis_tfirst(s_axis_tfirst),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tnext(m_axis_tnext), .m_axis_tdata(m_axis_tdata), .m_axis_tfirst(m_axis_tfirst),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .occupancy(occupancy), .pad_count(pad_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic pushBlock(input logic last);
    for (int w = 0; w < J; w++) begin
      outWord_t o;
      o.data  = mBlock[LCM-1-w*M -: M];
      o.first = mFirst && (w == 0);
      o.last  = last && (w == J - 1);
      expQ.push_back(o);
    end
    mIdx = 0;
  endtask

  task automatic padOut(input logic last);
    while (mIdx < K) begin
      mBlock[LCM-1-mIdx*N -: N] = PAD;
      if (mPad < 65535) mPad++;
      mIdx++;
    end
    pushBlock(last);
  endtask

  task automatic modelAccept(input inWord_t w);
    if (mIdx == 0) mFirst = w.first;
    mBlock[LCM-1-mIdx*N -: N] = w.data;
    mIdx++;
    if (mIdx == K) pushBlock(w.last);
    else if (w.last) padOut(1'b1);
  endtask

  task automatic modelReset();
    expQ.delete();
    mIdx = 0;
    mPad = 0;
    mBlock = '0;
  endtask

  task automatic driveInputs();
    if (stimQ.size() > 0) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = stimQ[0].data;
      s_axis_tfirst = stimQ[0].first;
      s_axis_tlast  = stimQ[0].last;
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tfirst = 1'b0;
      s_axis_tlast  = 1'b0;
    end
    case (sinkMode)
      SINK_POP:  m_axis_tnext = 1'b1;
      SINK_HOLD: m_axis_tnext = 1'b0;
      default:   m_axis_tnext = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic applyStimulus(input logic [N-1:0] d, input logic f, input logic l);
    inWord_t w;
    w.data = d; w.first = f; w.last = l;
    stimQ.push_back(w);
    driveInputs();
  endtask

  // One clock: observe handshakes mid-cycle, then update drivers just after the edge.
  task automatic step(output bit prog);
    bit acc;
    outWord_t e;
    prog = 1'b0;
    @(negedge clk);
    if (s_axis_tnext && !s_axis_tvalid) checkOutput("tnextWithoutValid", 1, 0);
    if (s_axis_tvalid && stimQ.size() > 0 && stimQ[0].first && mIdx != 0) padOut(1'b0);
    acc = s_axis_tvalid && s_axis_tnext;
    if (acc) begin
      modelAccept(stimQ[0]);
      acceptedCount++;
      prog = 1'b1;
    end
    if (m_axis_tvalid && m_axis_tnext) begin
      prog = 1'b1;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedOutput", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("outWord", {25'b0, m_axis_tfirst, m_axis_tlast, m_axis_tdata},
                    {25'b0, e.first, e.last, e.data});
      end
    end
    @(posedge clk);
    #1;
    if (acc) void'(stimQ.pop_front());
    driveInputs();
  endtask

  task automatic runUntilDrained(input string label);
    int idle = 0;
    bit p;
    while ((stimQ.size() != 0 || expQ.size() != 0) && idle < 1000) begin
      step(p);
      idle = p ? 0 : idle + 1;
    end
    if (idle >= 1000) checkOutput({label, "_stall"}, 1, 0);
    checkOutput({label, "_padCount"}, 32'(pad_count), 32'(mPad));
    checkOutput({label, "_occupancyEmpty"}, 32'(occupancy), 0);
  endtask

  task automatic applyReset();
    rst = 1'b0;
    stimQ.delete();
    driveInputs();
    modelReset();
    #1;
    checkOutput("rstValid", 32'(m_axis_tvalid), 0);
    checkOutput("rstOccupancy", 32'(occupancy), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h5A;
    s_axis_tfirst = 1'b1;
    s_axis_tlast  = 1'b0;
    m_axis_tnext  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetTvalid", 32'(m_axis_tvalid), 0);
    checkOutput("resetTdata", 32'(m_axis_tdata), 0);
    checkOutput("resetTfirst", 32'(m_axis_tfirst), 0);
    checkOutput("resetTlast", 32'(m_axis_tlast), 0);
    checkOutput("resetOccupancy", 32'(occupancy), 0);
    checkOutput("resetPadCount", 32'(pad_count), 0);
    checkOutput("resetTnext", 32'(s_axis_tnext), 0);
    rst = 1'b1;
    modelReset();
    driveInputs();
    @(posedge clk);
    #1;

    sinkMode = SINK_POP;
    applyStimulus(8'h01, 1, 0); applyStimulus(8'h02, 0, 0); applyStimulus(8'h03, 0, 0);
    applyStimulus(8'h04, 0, 0); applyStimulus(8'h05, 0, 0);
    runUntilDrained("fullBlock");

    applyStimulus(8'hAA, 1, 0); applyStimulus(8'hBB, 0, 1);
    runUntilDrained("tlastFlush");

    applyStimulus(8'h11, 1, 0); applyStimulus(8'h22, 0, 0); applyStimulus(8'h33, 1, 1);
    runUntilDrained("tfirstFlush");

    // Backpressure: two blocks fill the ring, the third must not start.
    sinkMode = SINK_HOLD;
    acceptedCount = 0;
    for (int b = 0; b < 3; b++)
      for (int w = 0; w < K; w++) applyStimulus(8'(16 * b + w + 1), w == 0, 0);
    repeat (40) step(progress);
    checkOutput("holdAccepted", 32'(acceptedCount), 2 * K);
    checkOutput("holdOccupancy", 32'(occupancy), NBUF);
    checkOutput("holdTnext", 32'(s_axis_tnext), 0);
    sinkMode = SINK_POP;
    runUntilDrained("holdRelease");
    checkOutput("holdAllAccepted", 32'(acceptedCount), 3 * K);

    acceptedCount = 0;
    applyStimulus(8'hC1, 1, 0); applyStimulus(8'hC2, 0, 0); applyStimulus(8'hC3, 0, 0);
    for (int c = 0; c < 20 && acceptedCount < 3; c++) step(progress);
    stimQ.delete();
    applyReset();
    sinkMode = SINK_HOLD;
    for (int w = 0; w < K; w++) applyStimulus(8'hD0 + 8'(w), w == 0, 0);
    for (int c = 0; c < 30 && occupancy != 1; c++) step(progress);
    checkOutput("queuedOccupancy", 32'(occupancy), 1);
    applyReset();
    checkOutput("postResetPadCount", 32'(pad_count), 0);
    sinkMode = SINK_POP;
    for (int w = 0; w < K; w++) applyStimulus(8'hE0 + 8'(w * 3), w == 0, 0);
    runUntilDrained("afterReset");
    repeat (20) step(progress);

    sinkMode = SINK_RANDOM;
    for (int i = 0; i < 1024; i++)
      applyStimulus(8'($urandom_range(0, 255)), $urandom_range(0, 10) == 0,
                    (i == 1023) || ($urandom_range(0, 19) == 0));
    runUntilDrained("random");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
